// File: rtl/aes_stream_if.sv
// Streaming front-end for a 128-bit-parallel AES-128 encrypt engine.
// Key and plaintext arrive as BUS_W-bit beats, MSB-first, and are packed
// into 128-bit registers. The engine is then launched with a one-cycle
// pulse. Its ciphertext is streamed back out under valid/ready
// backpressure, and the block closes with a one-cycle DONE pulse.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_LOAD  | accepting key/plaintext beats (in_rdy high)
// S_START | one-cycle core_start pulse to the engine
// S_WAIT  | engine running; core_key/core_din held stable
// S_DRAIN | ciphertext beats presented on d_out with d_vld
// S_DONE  | one-cycle DONE pulse, then back to S_LOAD
module aes_stream_if #(
  parameter int BUS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic             key_load,
  input  logic [BUS_W-1:0] key_in,
  input  logic [BUS_W-1:0] d_in,
  output logic [BUS_W-1:0] d_out,
  output logic             d_vld,
  input  logic             out_rdy,
  output logic             DONE,
  output logic             busy,
  output logic             core_start,
  output logic [127:0]     core_key,
  output logic [127:0]     core_din,
  input  logic [127:0]     core_dout,
  input  logic             core_done
);

  localparam int BEATS = 128 / BUS_W;
  // A single-beat bus still gets a one-bit counter so the FSM is unchanged.
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Only the widths that divide a 128-bit block evenly are supported.
  if (!(BUS_W == 8 || BUS_W == 16 || BUS_W == 32 || BUS_W == 64 || BUS_W == 128))
  begin : g_bad_bus_w
    $error("aes_stream_if: BUS_W=%0d is not one of 8/16/32/64/128", BUS_W);
  end

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     data_q, data_d;
  logic [127:0]     out_q, out_d;
  logic             kl_q, kl_d;
  logic             in_rdy_q, in_rdy_d;
  logic             in_acc;
  logic             key_en;
  logic             last_beat;

  // Next-state, beat counting and shift-register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    data_d    = data_q;
    out_d     = out_q;
    kl_d      = kl_q;
    in_acc    = in_vld & in_rdy_q & (state_q == S_LOAD);
    last_beat = (cnt_q == LAST_BEAT);
    // key_load is only honoured on beat 0; later beats follow the latched flag.
    key_en    = (cnt_q == '0) ? key_load : kl_q;

    case (state_q)
      S_LOAD: begin
        if (in_acc) begin
          data_d = (data_q << BUS_W) | 128'(d_in);
          if (cnt_q == '0) begin
            kl_d = key_load;
          end
          if (key_en) begin
            key_d = (key_q << BUS_W) | 128'(key_in);
          end
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          out_d   = core_dout;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_rdy) begin
          out_d = out_q << BUS_W;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_LOAD;
      end
      default: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
    endcase

    // in_rdy is registered so it stays low while reset is held and rises on the first edge after.
    in_rdy_d = (state_d == S_LOAD);
  end

  // State and datapath registers; reset aborts any block in flight and clears the key.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_LOAD;
      cnt_q    <= '0;
      key_q    <= '0;
      data_q   <= '0;
      out_q    <= '0;
      kl_q     <= 1'b0;
      in_rdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      data_q   <= data_d;
      out_q    <= out_d;
      kl_q     <= kl_d;
      in_rdy_q <= in_rdy_d;
    end
  end

  assign in_rdy     = in_rdy_q;
  assign d_vld      = (state_q == S_DRAIN);
  assign DONE       = (state_q == S_DONE);
  assign busy       = (state_q != S_LOAD);
  assign core_start = (state_q == S_START);
  assign d_out      = out_q[127 -: BUS_W];
  assign core_key   = key_q;
  assign core_din   = data_q;

endmodule

// File: tb/tb_aes_stream_if.sv
// Directed + randomized bench for aes_stream_if at BUS_W=8 and BUS_W=32.
// Both instances share stimulus; 'sel' picks which one is driven and observed.
module tb_aes_stream_if;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         sel;
  logic         in_vld, key_load, out_rdy, core_done;
  logic [127:0] key_bus, d_bus, core_dout;

  logic         in_rdy8, d_vld8, done8, busy8, start8;
  logic [7:0]   d_out8;
  logic [127:0] key8, din8;
  logic         in_rdy32, d_vld32, done32, busy32, start32;
  logic [31:0]  d_out32;
  logic [127:0] key32, din32;

  logic         in_rdy_m, d_vld_m, done_m, busy_m, start_m;
  logic [127:0] d_out_m, key_m, din_m;

  aes_stream_if #(.BUS_W(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_vld(in_vld & ~sel), .in_rdy(in_rdy8),
    .key_load(key_load), .key_in(key_bus[7:0]), .d_in(d_bus[7:0]),
    .d_out(d_out8), .d_vld(d_vld8), .out_rdy(out_rdy & ~sel),
    .DONE(done8), .busy(busy8), .core_start(start8),
    .core_key(key8), .core_din(din8),
    .core_dout(core_dout), .core_done(core_done & ~sel)
  );

  aes_stream_if #(.BUS_W(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_vld(in_vld & sel), .in_rdy(in_rdy32),
    .key_load(key_load), .key_in(key_bus[31:0]), .d_in(d_bus[31:0]),
    .d_out(d_out32), .d_vld(d_vld32), .out_rdy(out_rdy & sel),
    .DONE(done32), .busy(busy32), .core_start(start32),
    .core_key(key32), .core_din(din32),
    .core_dout(core_dout), .core_done(core_done & sel)
  );

  assign in_rdy_m = sel ? in_rdy32 : in_rdy8;
  assign d_vld_m  = sel ? d_vld32  : d_vld8;
  assign done_m   = sel ? done32   : done8;
  assign busy_m   = sel ? busy32   : busy8;
  assign start_m  = sel ? start32  : start8;
  assign d_out_m  = sel ? {96'b0, d_out32} : {120'b0, d_out8};
  assign key_m    = sel ? key32 : key8;
  assign din_m    = sel ? din32 : din8;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Reference model state: the key each instance should present to the engine.
  logic [127:0] exp_key [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Beat i of a 128-bit vector at width w, MSB-first, right-aligned.
  function automatic logic [127:0] beat_of(input logic [127:0] v, input int w, input int i);
    logic [127:0] m;
    m = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
    return (v >> (128 - (i + 1) * w)) & m;
  endfunction

  // One full block on the selected instance; entered and left on a negedge.
  task automatic run_block(input logic kl, input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] ct, input bit gaps, input bit stall,
                           input bit abort);
    int w, nb, hold;
    w  = sel ? 32 : 8;
    nb = 128 / w;

    for (int i = 0; i < nb; i++) begin
      if (gaps) begin
        hold = $urandom_range(0, 2);
        for (int g = 0; g < hold; g++) begin
          in_vld = 1'b0; key_load = 1'b1; key_bus = rnd128(); d_bus = rnd128();
          @(negedge clk);
        end
      end
      chk("in_rdy_load", {127'b0, in_rdy_m}, 128'd1);
      in_vld   = 1'b1;
      key_load = (i == 0) ? kl : 1'($urandom_range(0, 1));
      key_bus  = beat_of(key, w, i);
      d_bus    = beat_of(pt, w, i);
      @(negedge clk);
    end
    in_vld = 1'b0; key_load = 1'b0; key_bus = rnd128(); d_bus = rnd128();
    if (kl) exp_key[sel] = key;

    chk("core_start_pulse", {127'b0, start_m}, 128'd1);
    chk("core_key", key_m, exp_key[sel]);
    chk("core_din", din_m, pt);
    chk("in_rdy_busy", {126'b0, in_rdy_m, busy_m}, 128'b01);
    @(negedge clk);
    chk("core_start_once", {127'b0, start_m}, 128'd0);

    if (abort) begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_outs", {122'b0, in_rdy_m, d_vld_m, done_m, busy_m, start_m, 1'b0}, 128'd0);
      chk("rst_dout", d_out_m, 128'd0);
      chk("rst_key", key_m, 128'd0);
      exp_key[0] = '0;
      exp_key[1] = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_no_done", {127'b0, done_m}, 128'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_release_rdy", {126'b0, in_rdy_m, done_m}, 128'b10);
      return;
    end

    repeat (8) @(negedge clk);
    chk("wait_no_vld", {127'b0, d_vld_m}, 128'd0);
    chk("wait_key_stable", key_m, exp_key[sel]);
    core_done = 1'b1;
    core_dout = ct;
    @(negedge clk);
    core_done = 1'b0;
    core_dout = rnd128();

    for (int i = 0; i < nb; i++) begin
      chk("d_vld", {127'b0, d_vld_m}, 128'd1);
      chk("d_out", d_out_m, beat_of(ct, w, i));
      chk("no_early_done", {127'b0, done_m}, 128'd0);
      hold = (stall && i == nb / 2) ? 3 : (gaps ? int'($urandom_range(0, 1)) : 0);
      out_rdy = 1'b0;
      for (int s = 0; s < hold; s++) begin
        @(negedge clk);
        chk("d_out_held", d_out_m, beat_of(ct, w, i));
        chk("d_vld_held", {127'b0, d_vld_m}, 128'd1);
      end
      out_rdy = 1'b1;
      @(negedge clk);
    end
    out_rdy = 1'b0;
    chk("done_pulse", {126'b0, done_m, d_vld_m}, 128'b10);
    @(negedge clk);
    chk("done_once", {125'b0, done_m, busy_m, in_rdy_m}, 128'b001);
  endtask

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    rst = 1'b0; sel = 1'b0;
    in_vld = 1'b0; key_load = 1'b0; out_rdy = 1'b0; core_done = 1'b0;
    key_bus = '0; d_bus = '0; core_dout = '0;
    exp_key[0] = '0; exp_key[1] = '0;

    @(negedge clk);
    chk("reset_outs", {123'b0, in_rdy_m, d_vld_m, done_m, busy_m, start_m}, 128'd0);
    chk("reset_dout", d_out_m, 128'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", {127'b0, in_rdy_m}, 128'd1);

    // BUS_W=8: reference vectors, key reuse, then randomized backpressure.
    run_block(1'b1, K0, P0, C0, 1'b0, 1'b0, 1'b0);
    run_block(1'b0, '1, P1, rnd128(), 1'b0, 1'b0, 1'b0);
    run_block(1'b1, rnd128(), rnd128(), rnd128(), 1'b1, 1'b1, 1'b0);
    run_block(1'b0, rnd128(), rnd128(), rnd128(), 1'b1, 1'b1, 1'b0);

    // Spurious engine completion while idle must be ignored.
    core_done = 1'b1;
    core_dout = rnd128();
    @(negedge clk);
    core_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("spurious_done", {125'b0, d_vld_m, busy_m, in_rdy_m}, 128'b001);
      @(negedge clk);
    end

    // BUS_W=32: same vectors, reuse, randomized stalls.
    sel = 1'b1;
    @(negedge clk);
    run_block(1'b1, K0, P0, C0, 1'b0, 1'b0, 1'b0);
    run_block(1'b0, '1, P1, rnd128(), 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      run_block(1'($urandom_range(0, 1)), rnd128(), rnd128(), rnd128(), 1'b1, 1'b1, 1'b0);
    end

    // Reset in S_WAIT, then fresh blocks on both widths.
    run_block(1'b1, rnd128(), rnd128(), rnd128(), 1'b0, 1'b0, 1'b1);
    run_block(1'b1, K0, P0, C0, 1'b1, 1'b0, 1'b0);
    sel = 1'b0;
    @(negedge clk);
    run_block(1'b0, rnd128(), P1, rnd128(), 1'b1, 1'b1, 1'b0);
    run_block(1'b1, rnd128(), rnd128(), C0, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
